decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue.sv | 180 ++++++++++++++++++
 tb/tb_decode_issue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// ============================================================================
// Module   : decode_issue
// Purpose  : RV32I decode/issue stage with a register scoreboard for RAW/WAW
//            interlock. Optional same-cycle writeback bypass: DECODE_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        in_valid,
    output logic             in_ready,
    input  wire logic [31:0] in_instr,
    input  wire logic [31:0] in_pc,
    output logic             out_valid,
    input  wire logic        out_ready,
    output logic [31:0]      out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_imm,
    output logic             out_we,
    output logic             out_illegal,
    output logic [4:0]       rf_r1,
    output logic [4:0]       rf_r2,
    output logic             rf_r_en,
    input  wire logic        wb_valid,
    input  wire logic [4:0]  wb_rd,
    input  wire logic        flush
);

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;
    logic        w_legal;
    logic        w_we_op;
    logic        w_use1;
    logic        w_use2;
    logic        w_we;
    logic        w_hazard;
    logic        w_accept;
    logic [31:0] w_wb_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_busy_eff;

    logic [31:0] r_busy;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [4:0]  r_rd;
    logic [31:0] r_imm;
    logic        r_we;
    logic        r_illegal;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];

    always_comb begin
        w_imm   = 32'h0;
        w_legal = 1'b0;
        w_we_op = 1'b0;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
                w_legal = 1'b1;
                w_we_op = 1'b1;
                w_use1  = 1'b1;
            end
            7'b0100011: begin
                w_imm   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_legal = 1'b1;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            7'b1100011: begin
                w_imm   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
                w_legal = 1'b1;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                w_imm   = {in_instr[31:12], 12'h0};
                w_legal = 1'b1;
                w_we_op = 1'b1;
            end
            7'b1101111: begin
                w_imm   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
                w_legal = 1'b1;
                w_we_op = 1'b1;
            end
            7'b0110011: begin
                w_legal = 1'b1;
                w_we_op = 1'b1;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_we       = w_we_op & (w_rd != 5'd0);
    assign w_wb_mask  = wb_valid ? (32'h1 << wb_rd) : 32'h0;
    assign w_set_mask = (w_accept & w_we) ? (32'h1 << w_rd) : 32'h0;

`ifdef DECODE_WB_BYPASS_EN
    // A same-cycle writeback lands in the register file before the read.
    assign w_busy_eff = r_busy & ~w_wb_mask;
`else
    assign w_busy_eff = r_busy;
`endif

    assign w_hazard = (w_use1 & w_busy_eff[w_rs1]) |
                      (w_use2 & w_busy_eff[w_rs2]) |
                      (w_we   & w_busy_eff[w_rd]);

    assign in_ready = (!r_valid | out_ready) & !w_hazard & !flush & !rst;
    assign w_accept = in_valid & in_ready;
    assign rf_r1    = w_rs1;
    assign rf_r2    = w_rs2;
    assign rf_r_en  = w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 32'h0;
            r_valid   <= 1'b0;
            r_pc      <= 32'h0;
            r_opcode  <= 7'h0;
            r_funct3  <= 3'h0;
            r_funct7  <= 7'h0;
            r_rd      <= 5'h0;
            r_imm     <= 32'h0;
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_busy  <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            // Set after clear so a same-cycle set/clear of one register keeps it busy.
            r_busy <= ((r_busy & ~w_wb_mask) | w_set_mask) & 32'hFFFF_FFFE;
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_pc      <= in_pc;
                r_opcode  <= w_opcode;
                r_funct3  <= in_instr[14:12];
                r_funct7  <= in_instr[31:25];
                r_rd      <= w_rd;
                r_imm     <= w_imm;
                r_we      <= w_we;
                r_illegal <= !w_legal;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_opcode  = r_opcode;
    assign out_funct3  = r_funct3;
    assign out_funct7  = r_funct7;
    assign out_rd      = r_rd;
    assign out_imm     = r_imm;
    assign out_we      = r_we;
    assign out_illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
// ============================================================================
// Module   : tb_decode_issue
// Purpose  : Directed self-checking bench for decode_issue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_we;
    logic        out_illegal;
    logic [4:0]  rf_r1;
    logic [4:0]  rf_r2;
    logic        rf_r_en;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_issue u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_funct3 (out_funct3),
        .out_funct7 (out_funct7),
        .out_rd     (out_rd),
        .out_imm    (out_imm),
        .out_we     (out_we),
        .out_illegal(out_illegal),
        .rf_r1      (rf_r1),
        .rf_r2      (rf_r2),
        .rf_r_en    (rf_r_en),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00A00293; in_pc = 32'h0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_rf_r_en", 32'(rf_r_en), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);

        // addi x5,x0,10
        rst = 1'b0;
        drive(32'h00A00293, 32'h100);
        #1;
        chk("addi_in_ready", 32'(in_ready), 32'd1);
        chk("addi_rf_r1", 32'(rf_r1), 32'd0);
        chk("addi_rf_r_en", 32'(rf_r_en), 32'd1);
        step();
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_rd", 32'(out_rd), 32'd5);
        chk("addi_imm", out_imm, 32'd10);
        chk("addi_we", 32'(out_we), 32'd1);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_opcode", 32'(out_opcode), 32'h13);

        // add x6,x5,x5 must wait for x5 writeback
        drive(32'h00528333, 32'h104);
        #1;
        chk("add_stall0", 32'(in_ready), 32'd0);
        step();
        chk("add_drain_valid", 32'(out_valid), 32'd0);
        chk("add_stall1", 32'(in_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
`ifdef DECODE_WB_BYPASS_EN
        chk("add_wb_cycle_ready", 32'(in_ready), 32'd1);
        step();
        wb_valid = 1'b0;
`else
        chk("add_wb_cycle_ready", 32'(in_ready), 32'd0);
        step();
        wb_valid = 1'b0;
        #1;
        chk("add_after_wb_ready", 32'(in_ready), 32'd1);
        step();
`endif
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_rd", 32'(out_rd), 32'd6);
        chk("add_imm", out_imm, 32'd0);
        chk("add_opcode", 32'(out_opcode), 32'h33);
        chk("add_we", 32'(out_we), 32'd1);

        // beq x1,x2,-4
        drive(32'hFE208EE3, 32'h108);
        #1;
        chk("beq_ready", 32'(in_ready), 32'd1);
        chk("beq_rf_r1", 32'(rf_r1), 32'd1);
        chk("beq_rf_r2", 32'(rf_r2), 32'd2);
        step();
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_we", 32'(out_we), 32'd0);
        chk("beq_opcode", 32'(out_opcode), 32'h63);

        // lw x7,8(x3) held off by 3 cycles of back-pressure
        out_ready = 1'b0;
        drive(32'h0081A383, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pc", out_pc, 32'h108);
            chk("bp_imm", out_imm, 32'hFFFF_FFFC);
        end
        out_ready = 1'b1;
        #1;
        chk("lw_ready", 32'(in_ready), 32'd1);
        step();
        chk("lw_rd", 32'(out_rd), 32'd7);
        chk("lw_imm", out_imm, 32'd8);
        chk("lw_funct3", 32'(out_funct3), 32'd2);
        chk("lw_we", 32'(out_we), 32'd1);

        // illegal opcode 0x7F with every field set
        drive(32'hFFFF_FFFF, 32'h110);
        #1;
        chk("ill_ready", 32'(in_ready), 32'd1);
        step();
        chk("ill_illegal", 32'(out_illegal), 32'd1);
        chk("ill_we", 32'(out_we), 32'd0);
        chk("ill_imm", out_imm, 32'h0);
        chk("ill_funct7", 32'(out_funct7), 32'h7F);

        // lui x5,0x12345 makes x5 busy again
        drive(32'h123452B7, 32'h114);
        step();
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_illegal", 32'(out_illegal), 32'd0);
        chk("lui_we", 32'(out_we), 32'd1);

        // flush with x5 and x7 busy; a same-cycle writeback is ignored
        in_valid = 1'b0; flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; wb_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        drive(32'h00728433, 32'h118);
        #1;
        chk("post_flush_ready", 32'(in_ready), 32'd1);
        step();
        chk("post_flush_rd", 32'(out_rd), 32'd8);

        // jal x0,-8: J immediate, rd=0 never writes
        drive(32'hFF9FF06F, 32'h11C);
        step();
        chk("jal_imm", out_imm, 32'hFFFF_FFF8);
        chk("jal_we", 32'(out_we), 32'd0);

        // sw x2,-4(x1)
        drive(32'hFE20AE23, 32'h120);
        step();
        chk("sw_imm", out_imm, 32'hFFFF_FFFC);
        chk("sw_we", 32'(out_we), 32'd0);

        // reset during held transfer drops the instruction and clears x8 busy
        out_ready = 1'b0;
        drive(32'h00940493, 32'h124);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        drive(32'h00840433, 32'h128);
        #1;
        chk("rst_mid_x8_free", 32'(in_ready), 32'd1);
        step();
        chk("rst_mid_issue", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
